// File: rtl/blink_pkg.sv
// Shared definitions for the blink monitor and its companion LED blinker.
//   blink_mon_state_e : monitor FSM encoding
//   BLINK_CBITS_DEF   : default interval counter width, matched by the blinker
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        LOCKED,
        STUCK
    } blink_mon_state_e;

    localparam int unsigned BLINK_CBITS_DEF = 27;

endpackage

// File: rtl/blink_edge_sync.sv
// Input conditioning for the blink monitor: a 2-flop synchronizer followed by
// edge detection. Build option BLINK_MON_GLITCH_FILTER_EN adds a filter that
// requires the synchronized level to hold for FILT cycles before an edge is
// reported.
// Ports:
//   clk    in  clock
//   rst    in  asynchronous active-high reset
//   led_in in  raw blink line, asynchronous to clk
//   edge_p out one-cycle pulse per accepted toggle of led_in
module blink_edge_sync
    import blink_pkg::*;
`ifdef BLINK_MON_GLITCH_FILTER_EN
#(
    parameter int unsigned FILT = 3
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic led_in,
    output logic edge_p
);

    logic sync1;
    logic sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= led_in;
            sync2 <= sync1;
        end
    end

`ifdef BLINK_MON_GLITCH_FILTER_EN
    localparam int unsigned RBITS = $clog2(FILT + 1);

    // level: last accepted line level. run: cycles sync2 has already differed
    // from it. The edge fires on the FILT-th consecutive differing cycle.
    logic             level;
    logic [RBITS-1:0] run;
    logic             differ;
    logic             ripe;

    always_comb begin
        differ = (sync2 != level);
        ripe   = (run == RBITS'(FILT - 1));
        edge_p = differ && ripe;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b0;
            run   <= '0;
        end else if (!differ) begin
            run <= '0;
        end else if (ripe) begin
            level <= sync2;
            run   <= '0;
        end else begin
            run <= run + RBITS'(1);
        end
    end
`else
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= sync2;
        end
    end

    always_comb begin
        edge_p = sync2 ^ prev;
    end
`endif

endmodule

// File: rtl/blink_monitor.sv
// Receive-side monitor for a blinking status line. Measures the interval
// between accepted toggles (half period), declares lock after LOCK_N
// consecutive measurements agree within TOL cycles, and flags a stuck line
// when the interval counter saturates without a toggle.
// Build option: BLINK_MON_GLITCH_FILTER_EN enables the FILT-cycle glitch
// filter in the input path (FILT is otherwise unused).
// Ports:
//   clk         in  clock
//   rst         in  asynchronous active-high reset
//   led_in      in  blink line, asynchronous to clk
//   half_period out last published interval between accepted toggles, cycles
//   period_vld  out one-cycle pulse when half_period is updated
//   locked      out high in LOCKED state
//   stuck       out high in STUCK state
module blink_monitor
    import blink_pkg::*;
#(
    parameter int unsigned CBITS  = BLINK_CBITS_DEF,
    parameter int unsigned TOL    = 2,
    parameter int unsigned LOCK_N = 4,
    parameter int unsigned FILT   = 3
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             led_in,
    output logic [CBITS-1:0] half_period,
    output logic             period_vld,
    output logic             locked,
    output logic             stuck
);

    localparam int unsigned MBITS = $clog2(LOCK_N + 1);

    if (CBITS < 2) begin : g_bad_cbits
        $error("blink_monitor: CBITS must be at least 2");
    end
    if (LOCK_N < 1) begin : g_bad_lock_n
        $error("blink_monitor: LOCK_N must be at least 1");
    end
    if (FILT < 1) begin : g_bad_filt
        $error("blink_monitor: FILT must be at least 1");
    end

    logic edge_p;

`ifdef BLINK_MON_GLITCH_FILTER_EN
    blink_edge_sync #(
        .FILT (FILT)
    ) u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .led_in (led_in),
        .edge_p (edge_p)
    );
`else
    blink_edge_sync u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .led_in (led_in),
        .edge_p (edge_p)
    );
`endif

    blink_mon_state_e state, state_n;
    logic [CBITS-1:0] cnt, cnt_n;
    logic [CBITS-1:0] prev_m, prev_m_n;
    logic             prev_vld, prev_vld_n;
    logic [MBITS-1:0] match_cnt, match_cnt_n;
    logic [MBITS-1:0] match_inc;
    logic [CBITS-1:0] m;
    logic [CBITS:0]   diff;
    logic [CBITS:0]   adiff;
    logic             sat;
    logic             match;
    logic             publish;

    always_comb begin
        sat = (cnt == '1);
        m   = sat ? '1 : cnt + CBITS'(1);

        // One extra bit so the difference of two unsigned CBITS values never
        // wraps; the top bit is then a true sign.
        diff  = {1'b0, m} - {1'b0, prev_m};
        adiff = diff[CBITS] ? ('0 - diff) : diff;
        match = prev_vld && (adiff <= (CBITS + 1)'(TOL));

        match_inc = match ? match_cnt + MBITS'(1) : MBITS'(1);

        state_n     = state;
        prev_m_n    = prev_m;
        prev_vld_n  = prev_vld;
        match_cnt_n = match_cnt;
        publish     = 1'b0;

        if (edge_p) begin
            cnt_n = '0;
        end else if (sat) begin
            cnt_n = cnt;
        end else begin
            cnt_n = cnt + CBITS'(1);
        end

        // An edge always takes priority over saturation in the same cycle.
        case (state)
            IDLE: begin
                if (edge_p) begin
                    state_n     = ACQ;
                    prev_vld_n  = 1'b0;
                    match_cnt_n = '0;
                end else if (sat) begin
                    state_n     = STUCK;
                    prev_vld_n  = 1'b0;
                    match_cnt_n = '0;
                end
            end
            ACQ: begin
                if (edge_p) begin
                    publish     = 1'b1;
                    prev_m_n    = m;
                    prev_vld_n  = 1'b1;
                    match_cnt_n = match_inc;
                    if (match_inc >= MBITS'(LOCK_N)) begin
                        state_n = LOCKED;
                    end
                end else if (sat) begin
                    state_n     = STUCK;
                    prev_vld_n  = 1'b0;
                    match_cnt_n = '0;
                end
            end
            LOCKED: begin
                if (edge_p) begin
                    publish    = 1'b1;
                    prev_m_n   = m;
                    prev_vld_n = 1'b1;
                    if (!match) begin
                        match_cnt_n = MBITS'(1);
                        state_n     = ACQ;
                    end
                end else if (sat) begin
                    state_n     = STUCK;
                    prev_vld_n  = 1'b0;
                    match_cnt_n = '0;
                end
            end
            STUCK: begin
                // First toggle after a stuck period only restarts timing.
                if (edge_p) begin
                    state_n     = ACQ;
                    prev_vld_n  = 1'b0;
                    match_cnt_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            prev_m      <= '0;
            prev_vld    <= 1'b0;
            match_cnt   <= '0;
            half_period <= '0;
            period_vld  <= 1'b0;
            locked      <= 1'b0;
            stuck       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            prev_m     <= prev_m_n;
            prev_vld   <= prev_vld_n;
            match_cnt  <= match_cnt_n;
            period_vld <= publish;
            if (publish) begin
                half_period <= m;
            end
            locked <= (state_n == LOCKED);
            stuck  <= (state_n == STUCK);
        end
    end

    a_lock_stuck_excl : assert property (@(posedge clk) disable iff (rst) !(locked && stuck));

endmodule

// File: tb/tb_blink_monitor.sv
// Directed self-checking bench for blink_monitor (CBITS=8, TOL=2, LOCK_N=4,
// FILT=3). Expected values are hand-computed; entries that depend on the
// glitch filter build option select between both sets of values.
module tb_blink_monitor;

    localparam int unsigned CBITS = 8;

`ifdef BLINK_MON_GLITCH_FILTER_EN
    localparam int LAT     = 5;
    localparam bit FILT_ON = 1'b1;
`else
    localparam int LAT     = 3;
    localparam bit FILT_ON = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             led_in;
    logic [CBITS-1:0] half_period;
    logic             period_vld;
    logic             locked;
    logic             stuck;

    int unsigned n_checks;
    int unsigned n_errors;

    blink_monitor #(
        .CBITS  (CBITS),
        .TOL    (2),
        .LOCK_N (4),
        .FILT   (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .led_in      (led_in),
        .half_period (half_period),
        .period_vld  (period_vld),
        .locked      (locked),
        .stuck       (stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input int vld, input int hp, input int lk, input int st);
        check({tag, ".vld"},    32'(period_vld),  vld);
        check({tag, ".hp"},     32'(half_period), hp);
        check({tag, ".locked"}, 32'(locked),      lk);
        check({tag, ".stuck"},  32'(stuck),       st);
    endtask

    // Entered and left LAT+1 cycles (+1ns) after the previous toggle, so the
    // toggle made here lands exactly n cycles after the previous one.
    task automatic blink(input string tag, input int n, input int vld, input int hp,
                         input int lk, input int st);
        repeat (n - LAT - 1) @(posedge clk);
        #1 led_in = ~led_in;
        repeat (LAT) @(posedge clk);
        #1 check_outs(tag, vld, hp, lk, st);
        @(posedge clk);
        #1 check({tag, ".pulse_end"}, 32'(period_vld), 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        led_in   = 1'b0;

        repeat (3) @(posedge clk);
        #1 check_outs("reset", 0, 0, 0, 0);
        rst = 1'b0;

        // Steady 10-cycle toggling: first edge only starts timing.
        blink("t1_first", 10, 0, 0, 0, 0);
        blink("t1_m1", 10, 1, 10, 0, 0);
        blink("t1_m2", 10, 1, 10, 0, 0);
        blink("t1_m3", 10, 1, 10, 0, 0);
        blink("t1_m4", 10, 1, 10, 1, 0);

        // Jitter within tolerance keeps lock.
        blink("t2_j12", 12, 1, 12, 1, 0);
        blink("t2_j11", 11, 1, 11, 1, 0);
        blink("t2_j9",   9, 1,  9, 1, 0);
        blink("t2_j11b", 11, 1, 11, 1, 0);
        // Step change drops lock on the same edge, then relock.
        blink("t2_step", 20, 1, 20, 0, 0);
        blink("t2_r2",   20, 1, 20, 0, 0);
        blink("t2_r3",   20, 1, 20, 0, 0);
        blink("t2_r4",   20, 1, 20, 1, 0);
        // Difference of exactly TOL+1 is a mismatch.
        blink("t2_tol3", 23, 1, 23, 0, 0);

        // Stuck line: saturation 256 cycles after the last accepted edge.
        repeat (254) @(posedge clk);
        #1 check_outs("t3_pre_stuck", 0, 23, 0, 0);
        @(posedge clk);
        #1 check_outs("t3_stuck", 0, 23, 0, 1);
        blink("t3_recover", 10, 0, 23, 0, 0);
        blink("t3_meas",    10, 1, 10, 0, 0);
        // Edge coinciding with saturation: publish all-ones, no STUCK.
        blink("t3_sat_edge", 256, 1, 255, 0, 0);

        blink("t4_m1", 10, 1, 10, 0, 0);
        blink("t4_m2", 10, 1, 10, 0, 0);
        blink("t4_m3", 10, 1, 10, 0, 0);
        blink("t4_m4", 10, 1, 10, 1, 0);

        // Reset while locked.
        rst    = 1'b1;
        led_in = 1'b0;
        #1 check_outs("t4_rst", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 check_outs("t4_rel", 0, 0, 0, 0);
        blink("t4_first", 10, 0, 0, 0, 0);
        blink("t4_meas",  10, 1, 10, 0, 0);

        // Glitches: 1-cycle pulse 10 cycles after the last edge, 2-cycle pulse
        // 8 cycles later, then a real toggle 30 cycles after the last edge.
        repeat (10 - LAT - 1) @(posedge clk);
        #1 led_in = ~led_in;
        @(posedge clk);
        #1 led_in = ~led_in;
        repeat (LAT - 1) @(posedge clk);
        #1 check("t5_g1a.vld", 32'(period_vld),  FILT_ON ? 0 : 1);
        check("t5_g1a.hp",     32'(half_period), 10);
        @(posedge clk);
        #1 check("t5_g1b.vld", 32'(period_vld),  FILT_ON ? 0 : 1);
        check("t5_g1b.hp",     32'(half_period), FILT_ON ? 10 : 1);

        repeat (8 - LAT - 1) @(posedge clk);
        #1 led_in = ~led_in;
        repeat (2) @(posedge clk);
        #1 led_in = ~led_in;
        repeat (LAT - 2) @(posedge clk);
        #1 check("t5_g2a.vld", 32'(period_vld),  FILT_ON ? 0 : 1);
        check("t5_g2a.hp",     32'(half_period), FILT_ON ? 10 : 7);
        repeat (2) @(posedge clk);
        #1 check("t5_g2b.vld", 32'(period_vld),  FILT_ON ? 0 : 1);
        check("t5_g2b.hp",     32'(half_period), FILT_ON ? 10 : 2);
        check("t5_g2b.stuck",  32'(stuck),       0);

        repeat (10 - LAT) @(posedge clk);
        #1 led_in = ~led_in;
        repeat (LAT) @(posedge clk);
        #1 check("t5_real.vld", 32'(period_vld),  1);
        check("t5_real.hp",     32'(half_period), FILT_ON ? 30 : 10);
        @(posedge clk);
        #1 check("t5_real.pulse_end", 32'(period_vld), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
